instr_encode_loader: RTL and testbench

- Inverse of the single-cycle CPU's opcode-to-control decode path.
- Accepts symbolic instructions (4-bit internal opcode plus register and immediate fields) over a valid/ready stream.
- Encodes each one into a 32-bit LEGv8 machine word and writes it sequentially into instruction memory, starting at a base byte address.
- Used by the testbench/boot path to load programs before the CPU is released from reset.

---
 rtl/instr_encode_loader.sv | 143 ++++++++++++++
 tb/tb_instr_encode_loader.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encode_loader.sv
// Program loader: encodes symbolic instructions into LEGv8 machine words and
// writes them sequentially into instruction memory, one word per cycle.
module instr_encode_loader #(
  parameter int ADDR_W    = 16,
  parameter int BASE_ADDR = 0,
  parameter int DEPTH     = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_last,
  input  logic [3:0]        in_op,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rn,
  input  logic [4:0]        in_rm,
  input  logic [25:0]       in_imm,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              busy,
  output logic              done,
  output logic              full,
  output logic              err,
  output logic [ADDR_W-1:0] word_count
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE, S_FULL} state_t;

  state_t            state_q;
  logic              in_ready_q, busy_q, done_q, full_q, err_q;
  logic              imem_we_q;
  logic [ADDR_W-1:0] imem_addr_q, ptr_q, wc_q;
  logic [31:0]       imem_wdata_q;
  logic              end_q, full_pend_q;
  logic [32:0]       enc_s;
  logic              accept_s;

  // Returns {legal, word}; legal=0 for unknown opcodes or out-of-range immediates.
  function automatic logic [32:0] encode(input logic [3:0] op, input logic [4:0] rd,
                                         input logic [4:0] rn, input logic [4:0] rm,
                                         input logic [25:0] imm);
    logic d_fit, b_fit;
    d_fit = (imm[25:8] == 18'h00000) || (imm[25:8] == 18'h3FFFF);
    b_fit = (imm[25:18] == 8'h00) || (imm[25:18] == 8'hFF);
    case (op)
      4'd1:  encode = {imm[25:12] == 14'd0, 10'b1001000100, imm[11:0], rn, rd};
      4'd2:  encode = {1'b1, 11'b10101011000, rm, 6'b000000, rn, rd};
      4'd3:  encode = {b_fit, 8'h54, imm[18:0], 5'b01011};
      4'd4:  encode = {1'b1, 6'b000101, imm};
      4'd5:  encode = {b_fit, 8'hB4, imm[18:0], rd};
      4'd6:  encode = {d_fit, 11'b11111000010, imm[8:0], 2'b00, rn, rd};
      4'd7:  encode = {imm[25:6] == 20'd0, 11'b11010011011, 5'd0, imm[5:0], rn, rd};
      4'd8:  encode = {imm[25:6] == 20'd0, 11'b11010011010, 5'd0, imm[5:0], rn, rd};
      4'd9:  encode = {1'b1, 11'b10011011000, rm, 6'b011111, rn, rd};
      4'd10: encode = {d_fit, 11'b11111000000, imm[8:0], 2'b00, rn, rd};
      4'd11: encode = {1'b1, 11'b11101011000, rm, 6'b000000, rn, rd};
      default: encode = {1'b0, 32'h00000000};
    endcase
  endfunction

  assign accept_s = (state_q == S_LOAD) && in_ready_q && in_valid;

  // Encoder for the instruction currently presented.
  always_comb begin
    enc_s = encode(in_op, in_rd, in_rn, in_rm, in_imm);
  end

  // Session FSM; end_q holds the session open for the cycle its final write issues.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      in_ready_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      full_q       <= 1'b0;
      err_q        <= 1'b0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= 32'h00000000;
      ptr_q        <= '0;
      wc_q         <= '0;
      end_q        <= 1'b0;
      full_pend_q  <= 1'b0;
    end else begin
      imem_we_q <= 1'b0;
      case (state_q)
        S_IDLE, S_DONE, S_FULL: begin
          if (start) begin
            state_q     <= S_LOAD;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b1;
            done_q      <= 1'b0;
            full_q      <= 1'b0;
            err_q       <= 1'b0;
            wc_q        <= '0;
            ptr_q       <= ADDR_W'(BASE_ADDR);
            end_q       <= 1'b0;
            full_pend_q <= 1'b0;
          end
        end
        S_LOAD: begin
          if (end_q) begin
            state_q <= full_pend_q ? S_FULL : S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            full_q  <= full_pend_q;
            end_q   <= 1'b0;
          end else if (accept_s) begin
            if (enc_s[32]) begin
              imem_we_q    <= 1'b1;
              imem_addr_q  <= ptr_q;
              imem_wdata_q <= enc_s[31:0];
              ptr_q        <= ptr_q + ADDR_W'(4);
              wc_q         <= wc_q + ADDR_W'(1);
            end else begin
              err_q <= 1'b1;
            end
            // This accept either closes the program or fills the last free word.
            if (in_last || (enc_s[32] && (wc_q == ADDR_W'(DEPTH - 1)))) begin
              end_q       <= 1'b1;
              in_ready_q  <= 1'b0;
              full_pend_q <= ~in_last;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign in_ready   = in_ready_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign full       = full_q;
  assign err        = err_q;
  assign imem_we    = imem_we_q;
  assign imem_addr  = imem_addr_q;
  assign imem_wdata = imem_wdata_q;
  assign word_count = wc_q;

endmodule

// File: tb/tb_instr_encode_loader.sv
// Directed and randomized bench for instr_encode_loader with an arithmetic
// encoding model; dut_b is a DEPTH=4 build for the full-session case.
module tb_instr_encode_loader;
  localparam int AW = 16;

  logic clk = 1'b0, reset = 1'b1, start_a = 1'b0, start_b = 1'b0;
  logic in_valid = 1'b0, in_last = 1'b0;
  logic [3:0] in_op = 4'd0;
  logic [4:0] in_rd = 5'd0, in_rn = 5'd0, in_rm = 5'd0;
  logic [25:0] in_imm = 26'd0;

  logic in_ready_a, imem_we_a, busy_a, done_a, full_a, err_a;
  logic [AW-1:0] imem_addr_a, word_count_a;
  logic [31:0] imem_wdata_a;
  logic in_ready_b, imem_we_b, busy_b, done_b, full_b, err_b;
  logic [AW-1:0] imem_addr_b, word_count_b;
  logic [31:0] imem_wdata_b;

  int errors = 0, checks = 0, writes_b = 0;
  logic [31:0] exp_data[$], got_data[$];
  logic [AW-1:0] exp_addr[$], got_addr[$];
  logic [AW-1:0] exp_ptr;

  instr_encode_loader #(.ADDR_W(AW), .BASE_ADDR(0), .DEPTH(1024)) u_dut_a (
    .clk(clk), .reset(reset), .start(start_a), .in_valid(in_valid), .in_ready(in_ready_a),
    .in_last(in_last), .in_op(in_op), .in_rd(in_rd), .in_rn(in_rn), .in_rm(in_rm),
    .in_imm(in_imm), .imem_we(imem_we_a), .imem_addr(imem_addr_a), .imem_wdata(imem_wdata_a),
    .busy(busy_a), .done(done_a), .full(full_a), .err(err_a), .word_count(word_count_a));

  instr_encode_loader #(.ADDR_W(AW), .BASE_ADDR(0), .DEPTH(4)) u_dut_b (
    .clk(clk), .reset(reset), .start(start_b), .in_valid(in_valid), .in_ready(in_ready_b),
    .in_last(in_last), .in_op(in_op), .in_rd(in_rd), .in_rn(in_rn), .in_rm(in_rm),
    .in_imm(in_imm), .imem_we(imem_we_b), .imem_addr(imem_addr_b), .imem_wdata(imem_wdata_b),
    .busy(busy_b), .done(done_b), .full(full_b), .err(err_b), .word_count(word_count_b));

  always #5 clk = ~clk;

  // Write monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (imem_we_a === 1'b1) begin
      got_data.push_back(imem_wdata_a);
      got_addr.push_back(imem_addr_a);
    end
    if (imem_we_b === 1'b1) writes_b++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_start(input bit b);
    if (b) start_b = 1'b1; else start_a = 1'b1;
    tick(1);
    start_a = 1'b0;
    start_b = 1'b0;
    exp_ptr = '0;
  endtask

  // Presents one instruction until accepted or the cycle budget runs out.
  task automatic send(input bit b, input logic [3:0] op, input logic [4:0] rd, input logic [4:0] rn,
                      input logic [4:0] rm, input logic [25:0] imm, input bit last,
                      input int limit, output bit acc, output int waited);
    in_valid = 1'b1; in_op = op; in_rd = rd; in_rn = rn; in_rm = rm; in_imm = imm; in_last = last;
    acc = 1'b0;
    waited = 0;
    while (!acc && waited < limit) begin
      @(negedge clk);
      if ((b ? in_ready_b : in_ready_a) === 1'b1) acc = 1'b1;
      else waited++;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    in_last = 1'b0;
  endtask

  task automatic expect_word(input logic [31:0] w);
    exp_data.push_back(w);
    exp_addr.push_back(exp_ptr);
    exp_ptr = exp_ptr + 16'd4;
  endtask

  task automatic compare_writes(input string tag);
    int n;
    check({tag, "_nwrites"}, got_data.size(), exp_data.size());
    n = (got_data.size() < exp_data.size()) ? got_data.size() : exp_data.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_addr%0d", tag, i), 32'(got_addr[i]), 32'(exp_addr[i]));
      check($sformatf("%s_data%0d", tag, i), got_data[i], exp_data[i]);
    end
    got_data.delete(); got_addr.delete(); exp_data.delete(); exp_addr.delete();
  endtask

  // Field placement by arithmetic weights; returns legality.
  function automatic bit model_encode(input int op, input int rd, input int rn, input int rm,
                                      input longint uimm, output logic [31:0] word);
    longint simm, w, rr;
    bit ok;
    simm = (uimm >= 64'd33554432) ? uimm - 64'd67108864 : uimm;
    rr = longint'(rn) * 32 + longint'(rd);
    ok = 1'b1;
    w = 0;
    case (op)
      1:  begin ok = (uimm <= 4095); w = longint'(580) * 4194304 + uimm * 1024 + rr; end
      2:  w = longint'(1368) * 2097152 + longint'(rm) * 65536 + rr;
      11: w = longint'(1880) * 2097152 + longint'(rm) * 65536 + rr;
      9:  w = longint'(1240) * 2097152 + longint'(rm) * 65536 + 31 * 1024 + rr;
      7:  begin ok = (uimm <= 63); w = longint'(1691) * 2097152 + uimm * 1024 + rr; end
      8:  begin ok = (uimm <= 63); w = longint'(1690) * 2097152 + uimm * 1024 + rr; end
      6:  begin ok = (simm >= -256 && simm <= 255);
                w = longint'(1986) * 2097152 + ((simm + 512) % 512) * 4096 + rr; end
      10: begin ok = (simm >= -256 && simm <= 255);
                w = longint'(1984) * 2097152 + ((simm + 512) % 512) * 4096 + rr; end
      4:  w = longint'(5) * 67108864 + uimm;
      3:  begin ok = (simm >= -262144 && simm <= 262143);
                w = longint'(84) * 16777216 + ((simm + 524288) % 524288) * 32 + 11; end
      5:  begin ok = (simm >= -262144 && simm <= 262143);
                w = longint'(180) * 16777216 + ((simm + 524288) % 524288) * 32 + rd; end
      default: ok = 1'b0;
    endcase
    word = w[31:0];
    return ok;
  endfunction

  initial begin
    bit acc;
    int waited, simm, nexp;
    bit exp_err, ok;
    logic [31:0] w;
    logic [3:0] r_op;
    logic [4:0] r_rd, r_rn, r_rm;
    logic [25:0] r_imm;

    // Reset state
    tick(3);
    check("rst_we", imem_we_a, 1'b0);     check("rst_ready", in_ready_a, 1'b0);
    check("rst_busy", busy_a, 1'b0);      check("rst_done", done_a, 1'b0);
    check("rst_full", full_a, 1'b0);      check("rst_err", err_a, 1'b0);
    check("rst_wc", word_count_a, 16'd0); check("rst_addr", imem_addr_a, 16'd0);
    check("rst_wdata", imem_wdata_a, 32'd0);
    reset = 1'b0;
    tick(1);

    // Single ADDI with last
    pulse_start(1'b0);
    check("t1_ready", in_ready_a, 1'b1);
    check("t1_busy", busy_a, 1'b1);
    send(1'b0, 4'd1, 5'd1, 5'd2, 5'd0, 26'd5, 1'b1, 20, acc, waited);
    check("t1_acc", acc, 1'b1);
    check("t1_we", imem_we_a, 1'b1);
    check("t1_addr", imem_addr_a, 16'h0000);
    check("t1_data", imem_wdata_a, 32'h91001441);
    tick(2);
    check("t1_done", done_a, 1'b1);   check("t1_wc", word_count_a, 16'd1);
    check("t1_busy0", busy_a, 1'b0);  check("t1_ready0", in_ready_a, 1'b0);
    check("t1_err", err_a, 1'b0);     check("t1_full", full_a, 1'b0);
    expect_word(32'h91001441);
    compare_writes("t1");

    // Back-to-back stream
    pulse_start(1'b0);
    send(1'b0, 4'd2, 5'd3, 5'd1, 5'd2, 26'd0, 1'b0, 20, acc, waited);
    check("t2_stall0", waited, 0);
    send(1'b0, 4'd4, 5'd0, 5'd0, 5'd0, 26'h3FFFFFF, 1'b0, 20, acc, waited);
    check("t2_stall1", waited, 0);
    send(1'b0, 4'd5, 5'd5, 5'd0, 5'd0, 26'd2, 1'b0, 20, acc, waited);
    check("t2_stall2", waited, 0);
    send(1'b0, 4'd6, 5'd4, 5'd6, 5'd0, 26'd8, 1'b0, 20, acc, waited);
    check("t2_stall3", waited, 0);
    send(1'b0, 4'd3, 5'd0, 5'd0, 5'd0, 26'd3, 1'b1, 20, acc, waited);
    check("t2_stall4", waited, 0);
    tick(2);
    check("t2_done", done_a, 1'b1);
    check("t2_wc", word_count_a, 16'd5);
    expect_word(32'hAB020023); expect_word(32'h17FFFFFF); expect_word(32'hB4000045);
    expect_word(32'hF84080C4); expect_word(32'h5400006B);
    compare_writes("t2");

    // Rejection, also a restart after done
    pulse_start(1'b0);
    check("t3_done_clr", done_a, 1'b0);
    check("t3_wc_clr", word_count_a, 16'd0);
    send(1'b0, 4'd13, 5'd1, 5'd1, 5'd1, 26'd0, 1'b0, 20, acc, waited);
    check("t3_acc_bad_op", acc, 1'b1);
    send(1'b0, 4'd1, 5'd1, 5'd1, 5'd0, 26'd5000, 1'b0, 20, acc, waited);
    check("t3_acc_bad_imm", acc, 1'b1);
    check("t3_err_mid", err_a, 1'b1);
    send(1'b0, 4'd9, 5'd0, 5'd1, 5'd2, 26'd0, 1'b1, 20, acc, waited);
    tick(2);
    check("t3_err", err_a, 1'b1);
    check("t3_done", done_a, 1'b1);
    check("t3_wc", word_count_a, 16'd1);
    expect_word(32'h9B027C20);
    compare_writes("t3");

    // DEPTH=4 build: six offered, four taken
    pulse_start(1'b1);
    for (int i = 0; i < 6; i++) begin
      send(1'b1, 4'd1, 5'(i), 5'd0, 5'd0, 26'(i), 1'b0, 10, acc, waited);
      check($sformatf("t4_acc%0d", i), acc, (i < 4) ? 1'b1 : 1'b0);
    end
    check("t4_writes", writes_b, 4);
    check("t4_full", full_b, 1'b1);   check("t4_done", done_b, 1'b1);
    check("t4_ready", in_ready_b, 1'b0);
    check("t4_busy", busy_b, 1'b0);   check("t4_wc", word_count_b, 16'd4);

    // Reset right after an accept
    pulse_start(1'b0);
    send(1'b0, 4'd1, 5'd7, 5'd7, 5'd0, 26'd1, 1'b0, 20, acc, waited);
    check("t5_we_pre", imem_we_a, 1'b1);
    reset = 1'b1;
    tick(1);
    check("t5_we", imem_we_a, 1'b0);    check("t5_busy", busy_a, 1'b0);
    check("t5_ready", in_ready_a, 1'b0); check("t5_wc", word_count_a, 16'd0);
    check("t5_done", done_a, 1'b0);     check("t5_addr", imem_addr_a, 16'd0);
    reset = 1'b0;
    tick(3);
    ok = model_encode(1, 7, 7, 0, 64'd1, w);
    expect_word(w);
    compare_writes("t5");

    // Valid with gaps
    pulse_start(1'b0);
    for (int i = 0; i < 3; i++) begin
      send(1'b0, 4'd2, 5'(i + 1), 5'(i + 2), 5'(i + 3), 26'd0, (i == 2), 20, acc, waited);
      ok = model_encode(2, i + 1, i + 2, i + 3, 64'd0, w);
      expect_word(w);
      tick(2);
    end
    check("t6_done", done_a, 1'b1);
    compare_writes("t6");

    // Randomized session against the model
    pulse_start(1'b0);
    nexp = 0;
    exp_err = 1'b0;
    for (int i = 0; i < 40; i++) begin
      r_op = 4'($urandom_range(0, 15));
      r_rd = 5'($urandom); r_rn = 5'($urandom); r_rm = 5'($urandom);
      case ($urandom_range(0, 3))
        0: simm = int'($urandom_range(0, 600)) - 300;
        1: simm = ($urandom_range(0, 1) ? 262143 : -262144) + int'($urandom_range(0, 2)) - 1;
        2: simm = int'($urandom);
        default: simm = int'($urandom_range(0, 5000));
      endcase
      r_imm = simm[25:0];
      send(1'b0, r_op, r_rd, r_rn, r_rm, r_imm, (i == 39), 20, acc, waited);
      check($sformatf("t7_acc%0d", i), acc, 1'b1);
      if (model_encode(int'(r_op), int'(r_rd), int'(r_rn), int'(r_rm), longint'(r_imm), w)) begin
        expect_word(w);
        nexp++;
      end else begin
        exp_err = 1'b1;
      end
      tick($urandom_range(0, 2));
    end
    tick(2);
    check("t7_done", done_a, 1'b1);
    check("t7_err", err_a, exp_err);
    check("t7_wc", word_count_a, nexp);
    compare_writes("t7");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
